fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle datapath's decode/execute.
- Owns the PC and issues in-order word requests to instruction memory through a valid/ready request channel.
- Buffers returned words with their PCs in a DEPTH-entry queue and presents {pc, instr} to the datapath through a valid/ready handshake.
- Handles redirects for branches and jumps by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the fetch stage.
// Imported by fetch_queue and fetch_unit.
package fetch_unit_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic              filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry ring of {pc, instr, filled}.
// Allocate at tail, fill at the oldest unfilled slot, pop at head.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc,
    input  logic [WORD_W-1:0]      alloc_pc,
    input  logic                   fill,
    input  logic [WORD_W-1:0]      fill_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   head_ptr;
    logic [AW-1:0]   tail_ptr;
    logic [AW-1:0]   fill_ptr;

    assign head = mem[head_ptr];

    // Ring update; a flush drops every entry, including any same-cycle alloc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].filled <= 1'b0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
        end else begin
            if (pop) begin
                mem[head_ptr].filled <= 1'b0;
                head_ptr <= head_ptr + AW'(1);
            end
            if (alloc) begin
                mem[tail_ptr].pc     <= alloc_pc;
                mem[tail_ptr].filled <= 1'b0;
                tail_ptr <= tail_ptr + AW'(1);
            end
            if (fill) begin
                mem[fill_ptr].instr  <= fill_data;
                mem[fill_ptr].filled <= 1'b1;
                fill_ptr <= fill_ptr + AW'(1);
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, redirect FSM and request credit for the fetch stage.
// Returned words are buffered in fetch_queue and handed to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [WORD_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [WORD_W-1:0] fetch_pc,
    output logic [WORD_W-1:0] fetch_instr
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_e            state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] target;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     count;
    logic              started;
    logic              req_fire;
    logic              pop;
    logic              fill;
    logic              flush;
    fetch_entry_t      head;

    assign target = redirect_pc & ~32'h3;

    assign fetch_valid = head.filled;
    assign fetch_pc    = head.pc;
    assign fetch_instr = head.instr;
    assign pop         = fetch_valid & fetch_ready;

    // A pop frees its slot in the same cycle, so a full queue may still issue.
    assign imem_req_valid = started & (state == FETCH)
                          & ((count < FULL) | pop);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign flush = (state == FETCH) & redirect_valid;
    assign fill  = (state == FETCH) & imem_resp_valid & ~redirect_valid;

    // Outstanding after this cycle; in DRAIN it is the count left to drop.
    assign inflight = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .alloc    (req_fire),
        .alloc_pc (pc),
        .fill     (fill),
        .fill_data(imem_resp_data),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .count    (count)
    );

    // PC and FETCH/DRAIN control; redirect wins over the pc+4 step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            outstanding <= '0;
            started     <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= inflight;
            unique case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= target;
                        if (inflight != '0) begin
                            state <= DRAIN;
                        end
                    end else if (req_fire) begin
                        pc <= pc + PC_STEP;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc <= target;
                    end
                    if (inflight == '0) begin
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench with a program-flow model.
// Memory model plus scoreboard of expected {pc, instr} in fetch order.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;

    fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rdy_pct = 100;
    int          last_due;
    int          occ;
    int          acc_cnt;
    int          resp_cnt;
    int          first_req_cyc;
    logic [31:0] next_req_pc;
    logic [31:0] arch_next;
    pend_t       pending[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] hs_log[$];
    int          hs_cyc_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic void model_reset();
        pending.delete();
        exp_q.delete();
        acc_log.delete();
        hs_log.delete();
        hs_cyc_log.delete();
        imem_resp_valid = 1'b0;
        last_due      = 0;
        occ           = 0;
        acc_cnt       = 0;
        resp_cnt      = 0;
        first_req_cyc = -1;
        next_req_pc   = RESET_PC;
        arch_next     = RESET_PC;
    endfunction

    // Memory: in-order responses, one per cycle, at or after their due cycle.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            imem_resp_valid = 1'b0;
            pending.delete();
        end else begin
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_of(pending[0].addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Monitor: observe every handshake mid-cycle and score it.
    always @(negedge clk) begin
        logic        pop_now;
        logic [31:0] tgt;
        int          stale_n;
        int          d;
        if (rst) begin
            pop_now = fetch_valid && fetch_ready;
            if (imem_resp_valid && pending.size() > 0) begin
                void'(pending.pop_front());
                resp_cnt++;
            end
            stale_n = 0;
            foreach (pending[i]) if (pending[i].stale) stale_n++;
            if (stale_n != 0) chk("drain_fetch_valid", 32'(fetch_valid), 0);
            if (imem_req_valid && imem_req_ready) begin
                chk("req_in_drain", stale_n, 0);
                chk("credit", 32'((occ - int'(pop_now)) < DEPTH), 1);
                chk("req_addr", imem_req_addr, next_req_pc);
                d = cyc + $urandom_range(lat_max, lat_min);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pending.push_back('{addr: imem_req_addr, due: d, stale: 1'b0});
                if (first_req_cyc < 0) first_req_cyc = cyc;
                acc_log.push_back(imem_req_addr);
                acc_cnt++;
                occ++;
                next_req_pc = next_req_pc + 32'd4;
            end
            if (pop_now) begin
                while (exp_q.size() < 4) begin
                    exp_q.push_back(arch_next);
                    arch_next = arch_next + 32'd4;
                end
                chk("fetch_pc", fetch_pc, exp_q[0]);
                chk("fetch_instr", fetch_instr, instr_of(exp_q[0]));
                void'(exp_q.pop_front());
                occ--;
                hs_log.push_back(fetch_pc);
                hs_cyc_log.push_back(cyc);
            end
            if (redirect_valid) begin
                tgt = {redirect_pc[31:2], 2'b00};
                foreach (pending[i]) pending[i].stale = 1'b1;
                next_req_pc = tgt;
                exp_q.delete();
                arch_next = tgt;
                occ = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        step();
        rst = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        acc_log.delete();
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            fetch_ready = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) begin
                redirect_valid = 1'b1;
                if ($urandom_range(3) == 0)
                    redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                else
                    redirect_pc = $urandom();
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        int hsn;
        int snap;
        rst = 1'b0;
        fetch_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        imem_resp_data = '0;
        model_reset();
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("rst_fetch_instr", fetch_instr, 0);

        // Streaming with 1-cycle memory.
        fetch_ready = 1'b1;
        step();
        rst = 1'b1;
        for (int i = 0; i < 60 && hs_cyc_log.size() < 16; i++) step();
        chk("stream_wait", 32'(hs_cyc_log.size() >= 16), 1);
        chk("first_req", at(acc_log, 0), RESET_PC);
        chk("startup_lat", 32'(at(hs_log, 0) == 0 ? hs_cyc_log[0] - first_req_cyc : -1), 2);
        chk("throughput", 32'(hs_cyc_log[15] - hs_cyc_log[0]), 15);
        chk("stream_pc1", at(hs_log, 1), 32'h4);
        chk("stream_pc2", at(hs_log, 2), 32'h8);

        // Backpressure: only DEPTH requests go out.
        fetch_ready = 1'b0;
        hard_reset();
        repeat (10) step();
        chk("bp_req_count", acc_cnt, DEPTH);
        chk("bp_req_valid", 32'(imem_req_valid), 0);
        fetch_ready = 1'b1;
        for (int i = 0; i < 20 && hs_log.size() < 2; i++) step();
        chk("bp_pop0", at(hs_log, 0), 32'h0);
        chk("bp_pop1", at(hs_log, 1), 32'h4);

        // Redirect with two responses in flight at latency 3.
        lat_min = 3;
        lat_max = 3;
        hard_reset();
        for (int i = 0; i < 20 && pending.size() != 2; i++) step();
        chk("drain_setup", pending.size(), 2);
        hsn = hs_log.size();
        redirect(32'h40);
        snap = resp_cnt;
        for (int i = 0; i < 30 && acc_log.size() < 1; i++) step();
        chk("drain_target_req", at(acc_log, 0), 32'h40);
        chk("drain_dropped", resp_cnt - snap, 2);
        for (int i = 0; i < 30 && hs_log.size() <= hsn; i++) step();
        chk("drain_target_fetch", at(hs_log, hsn), 32'h40);

        // Target alignment and PC wrap.
        lat_min = 1;
        lat_max = 1;
        hard_reset();
        repeat (5) step();
        redirect(32'h103);
        for (int i = 0; i < 20 && acc_log.size() < 1; i++) step();
        chk("align_req", at(acc_log, 0), 32'h100);
        redirect(32'hFFFF_FFFC);
        for (int i = 0; i < 20 && acc_log.size() < 2; i++) step();
        chk("wrap_req0", at(acc_log, 0), 32'hFFFF_FFFC);
        chk("wrap_req1", at(acc_log, 1), 32'h0);

        // Redirect in the same cycle as the handshake of pc 0x8.
        hard_reset();
        for (int i = 0; i < 20 && !(fetch_valid && fetch_pc == 32'h8); i++) step();
        hsn = hs_log.size();
        redirect(32'h200);
        for (int i = 0; i < 30 && hs_log.size() < hsn + 2; i++) step();
        chk("same_cycle_pop", at(hs_log, hsn), 32'h8);
        chk("same_cycle_next", at(hs_log, hsn + 1), 32'h200);

        // Random traffic, then an asynchronous reset between edges.
        lat_min = 1;
        lat_max = 4;
        rdy_pct = 70;
        random_phase(1200);
        #2;
        rst = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 0);
        chk("arst_fetch_valid", 32'(fetch_valid), 0);
        chk("arst_fetch_pc", fetch_pc, 0);
        chk("arst_fetch_instr", fetch_instr, 0);
        step();
        step();
        rst = 1'b1;
        fetch_ready = 1'b1;
        for (int i = 0; i < 30 && acc_log.size() < 1; i++) step();
        chk("arst_first_req", at(acc_log, 0), RESET_PC);
        random_phase(1200);

        // Liveness: the stream must keep flowing once redirects stop.
        fetch_ready = 1'b1;
        hsn = hs_log.size();
        for (int i = 0; i < 200 && hs_log.size() < hsn + 8; i++) step();
        chk("liveness", 32'(hs_log.size() >= hsn + 8), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
